// File: rtl/spi_resp_pkg.sv
// Shared definitions for the SPI register responder.
//   state_e      : responder FSM states
//   CMD_BITS     : command byte length (rw + 7-bit address)
//   DATA_BITS    : data byte length
//   FRAME_BITS   : full frame length
//   RW_WRITE     : value of the rw bit that selects a write
//   addr_valid() : full-width address range check against the bank size
package spi_resp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;

  localparam int   CMD_BITS   = 8;
  localparam int   DATA_BITS  = 8;
  localparam int   FRAME_BITS = CMD_BITS + DATA_BITS;
  localparam logic RW_WRITE   = 1'b1;

  // The whole 7-bit address is compared, so aliases above the bank never hit.
  function automatic logic addr_valid(input logic [6:0] addr, input int nregs);
    return int'(addr) < nregs;
  endfunction

endpackage

// File: rtl/pin_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin, with single-cycle rise and
// fall pulses derived from the synchronized level.
//   clk     in  system clock
//   rst_n   in  asynchronous active-low reset
//   pin     in  asynchronous pin
//   sync    out synchronized pin level
//   rise    out one-clk pulse on a synchronized 0->1 transition
//   fall    out one-clk pulse on a synchronized 1->0 transition
// RST_VAL sets the idle level the chain resets to, so no false edge is seen
// on reset release (chip select idles high, SPI clock idles low).
module pin_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= {SYNC_STAGES{RST_VAL}};
      prev_q  <= RST_VAL;
    end else begin
      chain_q <= {chain_q[SYNC_STAGES-2:0], pin};
      prev_q  <= chain_q[SYNC_STAGES-1];
    end
  end

  assign sync = chain_q[SYNC_STAGES-1];
  assign rise = sync & ~prev_q;
  assign fall = ~sync & prev_q;

endmodule

// File: rtl/spi_reg_responder.sv
// SPI target (mode 0, MSB first) giving an external host read/write access to
// a small bank of 8-bit registers. Frame: rw, 7-bit address, 8-bit data.
//   clk        in  system clock
//   rst_n      in  asynchronous active-low reset
//   ena        in  design selected; when low the FSM is held idle
//   sclk       in  SPI clock pin (asynchronous)
//   cs_n       in  SPI chip select pin, active low
//   mosi       in  SPI data in
//   miso       out SPI data out
//   miso_oe    out high while a selected read frame drives miso
//   regs_flat  out register bank, reg i at [8*i+7:8*i]
//   wr_pulse   out one-clk pulse when a register is written
//   wr_addr    out address of the last write, valid with wr_pulse
//
// state | meaning
// IDLE  | waiting for chip select to fall
// CMD   | shifting in rw + address (first 8 SCLK rises)
// DATA  | write: shifting in data; read: shifting rdata out on SCLK falls
// DONE  | frame complete, further SCLK edges ignored until cs_n rises
module spi_reg_responder
  import spi_resp_pkg::*;
#(
  parameter int         NREGS       = 4,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RESET_VAL   = 8'h00
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic                     sclk,
  input  logic                     cs_n,
  input  logic                     mosi,
  output logic                     miso,
  output logic                     miso_oe,
  output logic [NREGS*8-1:0]       regs_flat,
  output logic                     wr_pulse,
  output logic [$clog2(NREGS)-1:0] wr_addr
);

  localparam int AW = $clog2(NREGS);

  logic sclk_rise, sclk_fall, sclk_unused;
  logic cs_sync, cs_fall, cs_rise_unused;
  logic mosi_sync, mosi_rise_unused, mosi_fall_unused;

  pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .pin(sclk),
    .sync(sclk_unused), .rise(sclk_rise), .fall(sclk_fall)
  );

  pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst_n(rst_n), .pin(cs_n),
    .sync(cs_sync), .rise(cs_rise_unused), .fall(cs_fall)
  );

  // Same latency as the SCLK path, so mosi_sync is aligned with sclk_rise.
  pin_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .rst_n(rst_n), .pin(mosi),
    .sync(mosi_sync), .rise(mosi_rise_unused), .fall(mosi_fall_unused)
  );

  state_e     state_q;
  logic [3:0] bit_cnt_q;
  logic [6:0] shift_q;
  logic       rw_q;
  logic [6:0] addr_q;
  logic [6:0] miso_sr_q;
  logic [7:0] regs_q [NREGS];

  // The seven stored bits plus the bit arriving on this rise form a full byte.
  logic [7:0] frame_byte;
  logic [7:0] rdata;

  assign frame_byte = {shift_q, mosi_sync};

  // Read mux addressed by the live command byte so miso is ready at the 8th rise.
  always_comb begin
    rdata = 8'h00;
    if (addr_valid(frame_byte[6:0], NREGS)) begin
      rdata = regs_q[frame_byte[AW-1:0]];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      rw_q      <= 1'b0;
      addr_q    <= '0;
      miso_sr_q <= '0;
      miso      <= 1'b0;
      miso_oe   <= 1'b0;
      wr_pulse  <= 1'b0;
      wr_addr   <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else begin
      wr_pulse <= 1'b0;
      if (!ena || cs_sync) begin
        state_q <= IDLE;
        miso_oe <= 1'b0;
        miso    <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            if (cs_fall) begin
              state_q   <= CMD;
              bit_cnt_q <= '0;
            end
          end
          CMD: begin
            if (sclk_rise) begin
              shift_q   <= frame_byte[6:0];
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'(CMD_BITS - 1)) begin
                state_q <= DATA;
                rw_q    <= frame_byte[7];
                addr_q  <= frame_byte[6:0];
                if (frame_byte[7] != RW_WRITE) begin
                  miso_sr_q <= rdata[6:0];
                  miso      <= rdata[7];
                  miso_oe   <= 1'b1;
                end
              end
            end
          end
          DATA: begin
            if (sclk_rise) begin
              shift_q   <= frame_byte[6:0];
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'(FRAME_BITS - 1)) begin
                state_q <= DONE;
                miso_oe <= 1'b0;
                miso    <= 1'b0;
                if (rw_q == RW_WRITE && addr_valid(addr_q, NREGS)) begin
                  regs_q[addr_q[AW-1:0]] <= frame_byte;
                  wr_pulse               <= 1'b1;
                  wr_addr                <= addr_q[AW-1:0];
                end
              end
            end else if (sclk_fall && rw_q != RW_WRITE && bit_cnt_q > 4'(CMD_BITS)) begin
              // The fall right after the 8th rise keeps rdata[7] on the pin: the
              // host samples it on the 9th rise. Later falls advance one bit.
              miso_sr_q <= {miso_sr_q[5:0], 1'b0};
              miso      <= miso_sr_q[6];
            end
          end
          DONE: begin
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_flat
    assign regs_flat[8*g +: 8] = regs_q[g];
  end

endmodule

// File: tb/tb_spi_reg_responder.sv
module tb_spi_reg_responder;

  localparam int NREGS = 4;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena   = 1'b1;
  logic        sclk  = 1'b0;
  logic        cs_n  = 1'b1;
  logic        mosi  = 1'b0;
  logic        miso;
  logic        miso_oe;
  logic [31:0] regs_flat;
  logic        wr_pulse;
  logic [1:0]  wr_addr;

  int total = 0;
  int bad = 0;
  int oe_dis_cnt = 0;
  int pulse_cnt = 0;

  typedef struct {
    int         addr;
    logic [7:0] data;
  } wr_t;

  logic [7:0] model [NREGS];
  wr_t        exp_wr [$];
  logic [7:0] exp_rd [$];
  logic [7:0] act_rd [$];

  spi_reg_responder #(.NREGS(NREGS), .SYNC_STAGES(2), .RESET_VAL(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .regs_flat(regs_flat),
    .wr_pulse(wr_pulse), .wr_addr(wr_addr)
  );

  always #5 clk = ~clk;

  initial begin
    #3ms;
    $display("FAIL timeout: simulation did not finish, got running want done");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_regs();
    for (int i = 0; i < NREGS; i++) begin
      chk($sformatf("reg%0d", i), {24'd0, regs_flat[8*i +: 8]}, {24'd0, model[i]});
    end
  endtask

  // Host side of one frame: mode 0, data set while SCLK low, sampled on rise.
  task automatic spi_frame(input logic [15:0] word, input int nbits, input bit chk_oe,
                           input bit keep_cs, output logic [7:0] rd);
    logic b;
    rd = 8'h00;
    cs_n = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      if (i < 16) mosi = word[15-i];
      else        mosi = 1'($urandom_range(0, 1));
      wait_clk($urandom_range(5, 8));
      b = miso;
      if (i >= 8 && i < 16) rd[15-i] = b;
      if (i == 8 && chk_oe) chk("miso_oe_read", {31'd0, miso_oe}, 32'd1);
      sclk = 1'b1;
      wait_clk($urandom_range(5, 8));
      sclk = 1'b0;
    end
    if (!keep_cs) begin
      wait_clk(5);
      cs_n = 1'b1;
    end
  endtask

  task automatic do_frame(input bit wr, input logic [6:0] addr, input logic [7:0] data,
                          input int nbits, input int gap);
    logic [7:0] rd;
    bit full;
    full = (nbits >= 16) && (ena == 1'b1);
    if (full && wr && int'(addr) < NREGS) begin
      exp_wr.push_back('{int'(addr), data});
      model[addr[1:0]] = data;
    end
    if (full && !wr) exp_rd.push_back(int'(addr) < NREGS ? model[addr[1:0]] : 8'h00);
    spi_frame({wr, addr, data}, nbits, full && !wr, 1'b0, rd);
    if (full && !wr) act_rd.push_back(rd);
    wait_clk(gap);
    chk("miso_oe_idle", {31'd0, miso_oe}, 32'd0);
  endtask

  initial begin
    logic [7:0] rd_dummy;
    int         p0;
    for (int i = 0; i < NREGS; i++) model[i] = 8'h00;

    fork
      forever begin
        wr_t e;
        @(negedge clk);
        if (!ena && miso_oe) oe_dis_cnt++;
        if (rst_n && wr_pulse) begin
          pulse_cnt++;
          if (exp_wr.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_wr_pulse: got addr %0d want no pulse", wr_addr);
          end else begin
            e = exp_wr.pop_front();
            chk("wr_addr", {30'd0, wr_addr}, e.addr);
            chk("wr_data", {24'd0, regs_flat[8*e.addr +: 8]}, {24'd0, e.data});
          end
        end
        if (act_rd.size() > 0 && exp_rd.size() > 0) begin
          chk("read_byte", {24'd0, act_rd.pop_front()}, {24'd0, exp_rd.pop_front()});
        end
      end
    join_none

    // Reset state
    wait_clk(3);
    chk("rst_regs", regs_flat, 32'd0);
    chk("rst_miso", {31'd0, miso}, 32'd0);
    chk("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
    chk("rst_wr_pulse", {31'd0, wr_pulse}, 32'd0);
    chk("rst_wr_addr", {30'd0, wr_addr}, 32'd0);
    rst_n = 1'b1;
    wait_clk(5);

    // Write then read back addr 1
    do_frame(1'b1, 7'd1, 8'hA5, 16, 6);
    chk("t1_reg1", {24'd0, regs_flat[15:8]}, 32'hA5);
    do_frame(1'b0, 7'd1, 8'h00, 16, 6);

    // Out-of-range address: write dropped, read returns zero
    do_frame(1'b1, 7'd5, 8'h3C, 16, 6);
    do_frame(1'b0, 7'd5, 8'h00, 16, 6);
    check_regs();

    // Aborted write after 12 rises, then a full frame
    do_frame(1'b1, 7'd2, 8'hFF, 12, 6);
    chk("t3_abort_reg2", {24'd0, regs_flat[23:16]}, 32'h00);
    do_frame(1'b1, 7'd2, 8'hFF, 16, 6);
    chk("t3_full_reg2", {24'd0, regs_flat[23:16]}, 32'hFF);

    // Reset in the middle of a write to addr 3
    spi_frame({1'b1, 7'd3, 8'h77}, 10, 1'b0, 1'b1, rd_dummy);
    rst_n = 1'b0;
    wait_clk(2);
    chk("t4_regs", regs_flat, 32'd0);
    chk("t4_miso_oe", {31'd0, miso_oe}, 32'd0);
    chk("t4_wr_pulse", {31'd0, wr_pulse}, 32'd0);
    cs_n = 1'b1;
    wait_clk(2);
    rst_n = 1'b1;
    for (int i = 0; i < NREGS; i++) model[i] = 8'h00;
    wait_clk(5);
    do_frame(1'b1, 7'd3, 8'h4D, 16, 6);
    do_frame(1'b0, 7'd3, 8'h00, 16, 6);

    // Deselected design ignores a full write
    ena = 1'b0;
    do_frame(1'b1, 7'd0, 8'h11, 16, 6);
    chk("t5_oe_while_disabled", oe_dis_cnt, 0);
    ena = 1'b1;
    wait_clk(4);
    check_regs();

    // Back-to-back writes with extra SCLKs after bit 16
    p0 = pulse_cnt;
    do_frame(1'b1, 7'd0, 8'h01, 19, 4);
    do_frame(1'b1, 7'd3, 8'h02, 19, 4);
    wait_clk(6);
    chk("t6_pulses", pulse_cnt - p0, 2);
    check_regs();

    // Randomized traffic, including addresses well outside the bank
    for (int n = 0; n < 40; n++) begin
      logic [6:0] a;
      if ($urandom_range(0, 3) == 0) a = 7'($urandom_range(0, 127));
      else                           a = 7'($urandom_range(0, 7));
      do_frame(1'($urandom_range(0, 1)), a, 8'($urandom), 16, $urandom_range(4, 8));
    end

    wait_clk(20);
    chk("pending_writes", exp_wr.size(), 0);
    chk("pending_reads", exp_rd.size(), 0);
    check_regs();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
